// File: rtl/eth_irq_moderator_if.sv
// Pending/holdoff/ack inputs and interrupt outputs of the moderator.
// master: pending logic + host CSRs; slave: the moderator.
interface eth_irq_moderator_if #(
  parameter int timer_width_p = 16,
  parameter int count_width_p = 8
);
  logic                     rx_pending;
  logic                     tx_pending;
  logic [timer_width_p-1:0] holdoff;
  logic                     holdoff_v;
  logic                     irq_ack;
  logic                     irq_count_clear;
  logic                     irq;
  logic [1:0]               irq_cause;
  logic                     holdoff_active;
  logic [count_width_p-1:0] irq_count;

  modport master (
    output rx_pending, tx_pending,
    output holdoff, holdoff_v,
    output irq_ack, irq_count_clear,
    input  irq, irq_cause,
    input  holdoff_active, irq_count
  );

  modport slave (
    input  rx_pending, tx_pending,
    input  holdoff, holdoff_v,
    input  irq_ack, irq_count_clear,
    output irq, irq_cause,
    output holdoff_active, irq_count
  );
endinterface

// File: rtl/eth_irq_moderator.sv
// Ethernet interrupt moderator: holdoff delay before raising irq,
// minimum gap after ack, sticky cause snapshot, saturating count.
module eth_irq_moderator #(
  parameter int timer_width_p   = 16,
  parameter int count_width_p   = 8,
  parameter int reset_holdoff_p = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  eth_irq_moderator_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE, DELAY, ASSERT, GAP
  } state_e;

  state_e state_q, state_d;
  logic [timer_width_p-1:0] cnt_q, cnt_d;
  logic [timer_width_p-1:0] hold_q, hold_d;
  logic [1:0]               cause_q, cause_d;
  logic [count_width_p-1:0] count_q, count_d;
  logic [count_width_p-1:0] count_base;
  logic [1:0] pend;
  logic any_p, h_zero, cnt_zero, enter_assert;

  assign pend     = {bus_io.tx_pending, bus_io.rx_pending};
  assign any_p    = |pend;
  assign h_zero   = (hold_q == '0);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= timer_width_p'(reset_holdoff_p);
      cause_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_p) begin
          if (h_zero) begin
            state_d = ASSERT;
          end else begin
            state_d = DELAY;
            cnt_d   = hold_q - 1'b1;
          end
        end
      end
      DELAY: begin
        if (!any_p)        state_d = IDLE;
        else if (cnt_zero) state_d = ASSERT;
        else               cnt_d   = cnt_q - 1'b1;
      end
      ASSERT: begin
        // ack wins over a simultaneous pending drop
        if (bus_io.irq_ack) begin
          if (h_zero) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = hold_q - 1'b1;
          end
        end else if (!any_p) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_zero) state_d = any_p ? ASSERT : IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d = bus_io.holdoff_v ? bus_io.holdoff : hold_q;

    enter_assert = (state_d == ASSERT) && (state_q != ASSERT);

    cause_d = '0;
    if (enter_assert)              cause_d = pend;
    else if (state_d == ASSERT)    cause_d = cause_q | pend;

    count_base = bus_io.irq_count_clear ? '0 : count_q;
    count_d    = count_base;
    if (enter_assert && (count_base != '1))
      count_d = count_base + 1'b1;
  end

  always_comb begin
    bus_io.irq            = (state_q == ASSERT);
    bus_io.holdoff_active = (state_q == DELAY) || (state_q == GAP);
    bus_io.irq_cause      = cause_q;
    bus_io.irq_count      = count_q;
  end

endmodule

// File: doc/eth_irq_moderator.md
Name: eth_irq_moderator

Overview:
- Sits directly downstream of the Ethernet interrupt pending logic.
- Consumes the per-direction RX/TX interrupt-pending levels and drives the single interrupt line to the host interrupt controller.
- Applies a programmable holdoff delay before assertion and a minimum gap after each acknowledge, to coalesce bursts of packet events.
- Reports a cause snapshot and a saturating count of interrupts raised.

Parameters:
- timer_width_p, 16, width of holdoff register and delay/gap counter
- count_width_p, 8, width of the interrupt statistics counter
- reset_holdoff_p, 0, holdoff value loaded at reset

Ports:
- clk_i  in  1  clock; the block has one clock
- reset_i  in  1  asynchronous, active-high reset
- rx_pending_i  in  1  RX interrupt pending level (already gated by RX enable)
- tx_pending_i  in  1  TX interrupt pending level (already gated by TX enable)
- holdoff_i  in  timer_width_p  new holdoff value, in cycles
- holdoff_v_i  in  1  write strobe for holdoff_i
- irq_ack_i  in  1  single-cycle host acknowledge (CSR write)
- irq_count_clear_i  in  1  clears irq_count_o
- irq_o  out  1  interrupt line to host
- irq_cause_o  out  2  {tx,rx} cause bits latched while irq_o is high
- holdoff_active_o  out  1  high in DELAY or GAP
- irq_count_o  out  count_width_p  saturating count of ASSERT entries

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=IDLE, counter=0, holdoff_r=reset_holdoff_p
  - irq_o=0, irq_cause_o=0, holdoff_active_o=0, irq_count_o=0
- Define any_p = rx_pending_i | tx_pending_i. Define H = holdoff_r.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- holdoff_r:
  - Loads holdoff_i on holdoff_v_i.
  - The new value takes effect at the next counter load. A running DELAY/GAP count is unaffected.
- IDLE:
  - If any_p and H==0, go to ASSERT.
  - If any_p and H>0, go to DELAY and load counter=H-1.
  - Otherwise stay in IDLE.
  - Latency from any_p rising to irq_o=1 is exactly H+1 cycles.
- DELAY:
  - If !any_p, go to IDLE immediately (no interrupt; the pending condition disappeared).
  - Else if counter==0, go to ASSERT.
  - Else counter decrements by 1.
- ASSERT: irq_o=1.
  - On entry, irq_cause_o loads {tx_pending_i, rx_pending_i}.
  - While in ASSERT, irq_cause_o ORs in the live pending bits each cycle (sticky).
  - If irq_ack_i and H>0, go to GAP and load counter=H-1.
  - If irq_ack_i and H==0, go to IDLE.
  - Else if !any_p, go to IDLE (level-sensitive drop, e.g. the RX buffer was drained).
  - Ack and pending-drop in the same cycle: the ack takes precedence.
  - On leaving ASSERT, irq_o=0 and irq_cause_o=0 from the next cycle.
- GAP: irq_o=0.
  - When counter==0: go to ASSERT if any_p, else IDLE.
  - Otherwise decrement the counter.
  - Pending changes during GAP do not shorten the gap.
- irq_ack_i outside ASSERT is ignored.
- holdoff_active_o = (state==DELAY) | (state==GAP).
- irq_count_o:
  - Increments by 1 on each transition into ASSERT and saturates at all-ones.
  - irq_count_clear_i sets it to 0.
  - Clear and increment in the same cycle give a result of 1.
- Counter never underflows; it is only decremented when nonzero.

Test Plan:
- Reset with H=0; hold rx_pending_i=1 from cycle 5 -> irq_o=1 at cycle 6, irq_cause_o=2'b01, irq_count_o=1; pulse irq_ack_i at cycle 10 -> irq_o=0 at 11, then irq_o=1 at 12 (pending still high).
- Write holdoff=4; raise tx_pending_i at cycle t -> holdoff_active_o=1 on t+1..t+4, irq_o=1 at t+5, irq_cause_o=2'b10; raise rx_pending_i in ASSERT -> irq_cause_o=2'b11.
- H=4, rx pulse of 2 cycles -> DELAY entered then IDLE; irq_o never asserts; irq_count_o unchanged.
- H=3, in ASSERT with pending held: ack -> irq_o low exactly 3 cycles, reasserts on 4th; drop pending during GAP -> returns to IDLE, irq_o stays 0.
- In ASSERT, drop both pending bits with no ack -> irq_o=0 next cycle; ack and drop together with H=2 -> GAP entered, holdoff_active_o=1 for 2 cycles.
- count_width_p=2: raise 5 interrupts -> irq_count_o saturates at 3; irq_count_clear_i coincident with an ASSERT entry -> 1; assert reset_i asynchronously mid-DELAY -> all outputs 0 immediately, holdoff_r=reset_holdoff_p.
